// File: rtl/trit_pkg.sv
// Shared balanced-ternary definitions: trit encodings and sequencer state codes.
package trit_pkg;

  localparam logic [1:0] TRIT_POS  = 2'b10;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_NEG  = 2'b01;
  localparam logic [1:0] TRIT_ERR  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/or_te.sv
// Single-trit ternary OR leaf: c = max(a, b) over -1 < 0 < +1, err on any invalid code.
module or_te
  import trit_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] c,
  output logic       err
);

  // An invalid operand forces the error code onto c so callers never see a bogus value.
  always_comb begin
    err = (a == TRIT_ERR) || (b == TRIT_ERR);
    c   = TRIT_NEG;
    if (err) begin
      c = TRIT_ERR;
    end else if ((a == TRIT_POS) || (b == TRIT_POS)) begin
      c = TRIT_POS;
    end else if ((a == TRIT_ZERO) || (b == TRIT_ZERO)) begin
      c = TRIT_ZERO;
    end
  end

endmodule

// File: rtl/or_tv_seq.sv
// Serial trit-wise ternary OR of two N-trit words through one shared or_te gate,
// one trit per clock, LSB first, with valid/ready on both sides and error capture.
module or_tv_seq
  import trit_pkg::*;
#(
  parameter int N_TRITS = 9,
  parameter int IDX_W   = $clog2(N_TRITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*N_TRITS-1:0] a,
  input  logic [2*N_TRITS-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N_TRITS-1:0] c,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx,
  output logic                 busy
);

  localparam int W = 2 * N_TRITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TRITS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     c_q, c_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  logic [1:0] gate_a, gate_b, gate_c;
  logic       gate_err;

  assign gate_a = a_q[{cnt_q, 1'b0} +: 2];
  assign gate_b = b_q[{cnt_q, 1'b0} +: 2];

  or_te u_or_te (
    .a   (gate_a),
    .b   (gate_b),
    .c   (gate_c),
    .err (gate_err)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          c_d       = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        c_d[{cnt_q, 1'b0} +: 2] = gate_err ? TRIT_ERR : gate_c;
        // Only the first invalid position is recorded; later ones leave err_idx alone.
        if (gate_err && !err_q) begin
          err_d     = 1'b1;
          err_idx_d = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign c         = c_q;
  assign err       = err_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_or_tv_seq.sv
// Self-checking bench for or_tv_seq: a 3-trit instance driven from a directed vector
// table plus hand-written handshake/reset sequences, and a 9-trit instance swept over all pair codes.
module tb_or_tv_seq;

  logic clk;
  logic rst_n;

  // 3-trit instance signals
  logic       inValid3, inReady3, outValid3, outReady3, err3, busy3;
  logic [5:0] a3, b3, c3;
  logic [1:0] errIdx3;

  // 9-trit instance signals
  logic        inValid9, inReady9, outValid9, outReady9, err9, busy9;
  logic [17:0] a9, b9, c9;
  logic [3:0]  errIdx9;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] expC;
    logic       expErr;
    logic [1:0] expIdx;
  } vec3_t;

  vec3_t vecs[6];

  or_tv_seq #(.N_TRITS(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid3),
    .in_ready  (inReady3),
    .a         (a3),
    .b         (b3),
    .out_valid (outValid3),
    .out_ready (outReady3),
    .c         (c3),
    .err       (err3),
    .err_idx   (errIdx3),
    .busy      (busy3)
  );

  or_tv_seq #(.N_TRITS(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid9),
    .in_ready  (inReady9),
    .a         (a9),
    .b         (b9),
    .out_valid (outValid9),
    .out_ready (outReady9),
    .c         (c9),
    .err       (err9),
    .err_idx   (errIdx9),
    .busy      (busy9)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference trit arithmetic, done on signed integers rather than on codes
  function automatic int tritVal(input logic [1:0] t);
    case (t)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] tritEnc(input int v);
    if (v > 0) return 2'b10;
    if (v < 0) return 2'b01;
    return 2'b00;
  endfunction

  // Present one word to the 3-trit DUT (called #1 after an edge while idle),
  // scramble the operands right after capture, then count edges until out_valid.
  task automatic applyStimulus3(input logic [5:0] a, input logic [5:0] b, output int cycles);
    checkOutput("in_ready3 before accept", {31'b0, inReady3}, 32'd1);
    inValid3 = 1'b1;
    a3 = a;
    b3 = b;
    @(posedge clk);
    #1;
    inValid3 = 1'b0;
    a3 = ~a;
    b3 = ~b;
    cycles = 0;
    while (!outValid3 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!outValid3) checkOutput("out_valid3 timeout", {31'b0, outValid3}, 32'd1);
  endtask

  task automatic applyStimulus9(input logic [17:0] a, input logic [17:0] b, output int cycles);
    inValid9 = 1'b1;
    a9 = a;
    b9 = b;
    @(posedge clk);
    #1;
    inValid9 = 1'b0;
    cycles = 0;
    while (!outValid9 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!outValid9) checkOutput("out_valid9 timeout", {31'b0, outValid9}, 32'd1);
  endtask

  // Wait out the 3-trit result and complete its handshake with out_ready already high
  task automatic finishWord3(input string tag);
    int cycles;
    cycles = 0;
    while (!outValid3 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!outValid3) checkOutput({tag, " timeout"}, {31'b0, outValid3}, 32'd1);
  endtask

  task automatic handshake3(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid after hs"}, {31'b0, outValid3}, 32'd0);
    checkOutput({tag, " in_ready after hs"}, {31'b0, inReady3}, 32'd1);
    checkOutput({tag, " busy after hs"}, {31'b0, busy3}, 32'd0);
  endtask

  task automatic checkReset3(input string tag);
    checkOutput({tag, " in_ready"}, {31'b0, inReady3}, 32'd1);
    checkOutput({tag, " out_valid"}, {31'b0, outValid3}, 32'd0);
    checkOutput({tag, " busy"}, {31'b0, busy3}, 32'd0);
    checkOutput({tag, " c"}, {26'b0, c3}, 32'd0);
    checkOutput({tag, " err"}, {31'b0, err3}, 32'd0);
    checkOutput({tag, " err_idx"}, {30'b0, errIdx3}, 32'd0);
  endtask

  // Main test sequence
  initial begin
    int cycles;
    logic [5:0] heldC;
    logic [17:0] wa, wb, expC9;
    logic expErr9;
    logic [3:0] expIdx9;
    logic [3:0] code;

    vecs[0] = '{6'b100001, 6'b010110, 6'b100010, 1'b0, 2'd0};
    vecs[1] = '{6'b110000, 6'b001100, 6'b111100, 1'b1, 2'd1};
    vecs[2] = '{6'b010101, 6'b010101, 6'b010101, 1'b0, 2'd0};
    vecs[3] = '{6'b001001, 6'b010100, 6'b001000, 1'b0, 2'd0};
    vecs[4] = '{6'b111111, 6'b000000, 6'b111111, 1'b1, 2'd0};
    vecs[5] = '{6'b100100, 6'b110001, 6'b110000, 1'b1, 2'd2};

    rst_n = 1'b0;
    inValid3 = 1'b0; outReady3 = 1'b1; a3 = '0; b3 = '0;
    inValid9 = 1'b0; outReady9 = 1'b1; a9 = '0; b9 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkReset3("reset");
    checkOutput("reset in_ready9", {31'b0, inReady9}, 32'd1);
    checkOutput("reset c9", {14'b0, c9}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      applyStimulus3(vecs[i].a, vecs[i].b, cycles);
      checkOutput($sformatf("v%0d latency", i), cycles, 32'd3);
      checkOutput($sformatf("v%0d c", i), {26'b0, c3}, {26'b0, vecs[i].expC});
      checkOutput($sformatf("v%0d err", i), {31'b0, err3}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("v%0d err_idx", i), {30'b0, errIdx3}, {30'b0, vecs[i].expIdx});
      checkOutput($sformatf("v%0d busy", i), {31'b0, busy3}, 32'd1);
      checkOutput($sformatf("v%0d in_ready", i), {31'b0, inReady3}, 32'd0);
      handshake3($sformatf("v%0d", i));
    end

    // Backpressure: result held stable while out_ready is low
    outReady3 = 1'b0;
    applyStimulus3(6'b101010, 6'b101010, cycles);
    checkOutput("bp c", {26'b0, c3}, {26'b0, 6'b101010});
    heldC = 6'b101010;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp out_valid %0d", k), {31'b0, outValid3}, 32'd1);
      checkOutput($sformatf("bp c stable %0d", k), {26'b0, c3}, {26'b0, heldC});
      checkOutput($sformatf("bp in_ready %0d", k), {31'b0, inReady3}, 32'd0);
    end
    outReady3 = 1'b1;
    handshake3("bp");

    // Second in_valid pulse during RUN must be ignored
    inValid3 = 1'b1; a3 = 6'b100001; b3 = 6'b010110;
    @(posedge clk);
    #1;
    inValid3 = 1'b0;
    @(posedge clk);
    #1;
    inValid3 = 1'b1; a3 = 6'b010101; b3 = 6'b010101;
    @(posedge clk);
    #1;
    inValid3 = 1'b0;
    finishWord3("ign");
    checkOutput("ign c", {26'b0, c3}, {26'b0, 6'b100010});
    checkOutput("ign err", {31'b0, err3}, 32'd0);
    handshake3("ign");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("ign no second word %0d", k), {31'b0, busy3 | outValid3}, 32'd0);
    end

    // in_valid held through RUN/DONE: next word captured only once IDLE is back
    inValid3 = 1'b1; a3 = 6'b000001; b3 = 6'b000000;
    @(posedge clk);
    #1;
    a3 = 6'b100000; b3 = 6'b000000;
    finishWord3("held1");
    checkOutput("held first c", {26'b0, c3}, {26'b0, 6'b000000});
    handshake3("held");
    @(posedge clk);
    #1;
    inValid3 = 1'b0;
    checkOutput("held recapture busy", {31'b0, busy3}, 32'd1);
    finishWord3("held2");
    checkOutput("held second c", {26'b0, c3}, {26'b0, 6'b100000});
    handshake3("held2");

    // Reset asserted after one RUN cycle drops the word
    inValid3 = 1'b1; a3 = 6'b101010; b3 = 6'b000000;
    @(posedge clk);
    #1;
    inValid3 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset3("midrun reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post reset no out_valid %0d", k), {31'b0, outValid3}, 32'd0);
    end
    applyStimulus3(6'b000000, 6'b010101, cycles);
    checkOutput("post reset latency", cycles, 32'd3);
    checkOutput("post reset c", {26'b0, c3}, 32'd0);
    checkOutput("post reset err", {31'b0, err3}, 32'd0);
    handshake3("post reset");

    // 9-trit sweep: word w puts pair code (w+i)%16 on trit i, covering every code at every position
    for (int w = 0; w < 16; w++) begin
      expErr9 = 1'b0;
      expIdx9 = '0;
      for (int i = 0; i < 9; i++) begin
        code = 4'((w + i) % 16);
        wa[2*i +: 2] = code[3:2];
        wb[2*i +: 2] = code[1:0];
        if (code[3:2] == 2'b11 || code[1:0] == 2'b11) begin
          expC9[2*i +: 2] = 2'b11;
          if (!expErr9) expIdx9 = 4'(i);
          expErr9 = 1'b1;
        end else begin
          expC9[2*i +: 2] = tritEnc((tritVal(code[3:2]) > tritVal(code[1:0])) ?
                                    tritVal(code[3:2]) : tritVal(code[1:0]));
        end
      end
      applyStimulus9(wa, wb, cycles);
      checkOutput($sformatf("sweep%0d latency", w), cycles, 32'd9);
      checkOutput($sformatf("sweep%0d c", w), {14'b0, c9}, {14'b0, expC9});
      checkOutput($sformatf("sweep%0d err", w), {31'b0, err9}, {31'b0, expErr9});
      checkOutput($sformatf("sweep%0d err_idx", w), {28'b0, errIdx9}, {28'b0, expIdx9});
      @(posedge clk);
      #1;
      checkOutput($sformatf("sweep%0d hs", w), {31'b0, outValid9}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/or_tv_seq.md
Name: or_tv_seq

Overview:
- Serial sequencer that computes the trit-wise ternary OR (max) of two N-trit words using a single shared or_te gate, one trit per clock.
- Sits between the register file / ALU operand bus and the or_te leaf cell.
- Valid/ready handshake on both input and output, with per-word error reporting.
- Trit encoding: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1, 2'b11 = invalid.

Parameters:
- N_TRITS, 9, number of trits per operand word (9 = one tryte); must be >= 2.
- IDX_W, $clog2(N_TRITS), width of the trit index and counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  sequencer can accept operands.
- a  in  2*N_TRITS  operand A; trit i occupies bits [2i+1:2i].
- b  in  2*N_TRITS  operand B; same packing as a.
- out_valid  out  1  result c/err/err_idx valid.
- out_ready  in  1  consumer accepts result.
- c  out  2*N_TRITS  result word, same packing.
- err  out  1  at least one invalid trit pair occurred in this word.
- err_idx  out  IDX_W  index of the lowest-numbered invalid trit; 0 when err = 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low: assertion immediately forces the reset values below; deassertion is synchronized externally.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, c = 0, err = 0, err_idx = 0, counter = 0, operand registers = 0.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready: latch a and b, clear c/err/err_idx, set cnt = 0, go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle, trit cnt of the latched A and B drives the single or_te instance (combinational).
  - At the edge: write the gate's c into result trit cnt.
  - If the gate's err = 1: write 2'b11 into result trit cnt, regardless of the gate's c. If err was still 0, set err = 1 and err_idx = cnt.
  - Processing is LSB first (trit 0 first) and never aborts on error; all N_TRITS positions are processed.
  - When cnt == N_TRITS-1: go to DONE at that edge; cnt wraps to 0.
- DONE:
  - out_valid = 1; c, err and err_idx stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE and clear out_valid. in_ready rises in the next cycle (one bubble).
- Latency: the acceptance edge is E0. out_valid is high after edge E0+N_TRITS. Throughput is one word per N_TRITS+2 cycles with out_ready tied high.
- Gate semantics (or_te): c = max(a, b) over -1 < 0 < +1; err = 1 iff either input is 2'b11.
- Boundaries:
  - in_valid held high during RUN/DONE: no second capture. The new word is taken only once IDLE is re-entered, and only if in_valid is still high.
  - out_ready high before out_valid: no effect.
  - rst_n asserted mid-RUN or in DONE: the word is dropped, all outputs return to reset values, no out_valid pulse.
  - Operand inputs changing after capture do not affect the result.

Decomposition:
- Shared package trit_pkg:
  - Constants TRIT_POS = 2'b10, TRIT_ZERO = 2'b00, TRIT_NEG = 2'b01, TRIT_ERR = 2'b11.
  - State encoding for IDLE, RUN, DONE.
- Sub-module: reuse the existing or_te leaf unchanged, instantiated once.
- Sequencer FSM, counter, and result/error registers live in or_tv_seq.

Test Plan (N_TRITS = 3 unless noted; words written trit2_trit1_trit0):
- Basic OR: a = 10_00_01, b = 01_01_10, out_ready = 1 -> c = 10_00_10, err = 0, err_idx = 0; out_valid high exactly 3 cycles after the acceptance edge.
- Error capture: a = 11_00_00, b = 00_11_00 -> c = 11_11_00, err = 1, err_idx = 1 (lowest invalid index); the word still completes in 3 cycles.
- Backpressure: a = b = 10_10_10 with out_ready low for 5 cycles -> out_valid held, c = 10_10_10 stable; in_ready stays 0 until the cycle after the handshake.
- Input ignored while busy: a second in_valid pulse with a = 01_01_01 during RUN -> not captured; first result unchanged; only one out_valid handshake.
- Reset mid-RUN: assert rst_n = 0 after 1 RUN cycle -> all outputs return to reset values immediately; after release, in_ready = 1 and a fresh word a = 00_00_00, b = 01_01_01 gives c = 00_00_00.
- Exhaustive: N_TRITS = 9, all 16 trit-pair codes swept across positions -> every c trit matches the max rule (2'b11 where invalid), err_idx = lowest invalid position.
